// File: rtl/dmem_bus.sv
// dmem_bus: single-outstanding data-memory bus slave.
//
// Decodes one request at a time into on-chip RAM, three read-only ID words,
// a read-only switch port and a read/write LED register.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   req_valid/req_ready    request handshake (req_ready only in IDLE)
//   req_addr/req_wdata     byte address and write data
//   req_we                 per-byte write enables, 0 means read
//   rsp_valid/rsp_ready    response handshake (rsp_valid only in RESP)
//   rsp_rdata/rsp_err      read data (0 for writes and errors), error flag
//   sw_in / led_out        switch inputs / LED register
//   dbg_state              current FSM state (0 = IDLE, 1 = RESP)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the sender holds its payload stable from valid=1 until that edge,
// and ready never depends combinationally on the same channel's valid.
//
// Build option: define DMEM_SW_SYNC_EN to pass sw_in through a 2-flop
// synchronizer; otherwise sw_in is sampled directly when a read is accepted.
module dmem_bus #(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] RAM_BASE  = 32'h8000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h0010_0000,
  parameter logic [31:0] ID0       = 32'h1387_4751,
  parameter logic [31:0] ID1       = 32'h1870_0095,
  parameter logic [31:0] ID2       = 32'h1831_3324,
  parameter int          SW_W      = 16,
  parameter int          LED_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_we,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out,
  output logic             dbg_state
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t state_q, state_d;
  // Cleared by reset, set on the first edge afterwards: keeps req_ready low
  // while rst is high even though the state register already sits in IDLE.
  logic   live_q;
  logic   accept;

  logic [31:0]      ram [RAM_WORDS];
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_val;

  logic [31:0] mmio_off, ram_off, sw_ext, led_wide, rd_word;
  logic [AW-1:0] ram_idx;
  logic aligned, is_write, ram_hit, led_hit, mapped, read_only, err;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = live_q;
        if (req_valid && live_q) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = req_valid && req_ready;
  assign dbg_state = state_q;

  // ---------------- switch source ----------------
`ifdef DMEM_SW_SYNC_EN
  logic [SW_W-1:0] sw_s1, sw_s2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
    end
  end
  assign sw_val = sw_s2;
`else
  assign sw_val = sw_in;
`endif

  // ---------------- address decode ----------------
  assign mmio_off = req_addr - MMIO_BASE;
  assign ram_off  = req_addr - RAM_BASE;
  assign aligned  = (req_addr[1:0] == 2'b00);
  assign is_write = |req_we;
  // The lower-bound test keeps ram_off from wrapping, so one compare bounds it.
  assign ram_hit  = (req_addr >= RAM_BASE) && (ram_off < RAM_BYTES);
  assign ram_idx  = ram_off[AW+1:2];
  assign led_hit  = (mmio_off == 32'h14);

  always_comb begin
    sw_ext = '0;
    sw_ext[SW_W-1:0] = sw_val;
    led_wide = '0;
    led_wide[LED_W-1:0] = led_q;
    for (int i = 0; i < 4; i++)
      if (req_we[i]) led_wide[8*i +: 8] = req_wdata[8*i +: 8];
  end

  always_comb begin
    rd_word   = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    if (mmio_off == 32'h00) begin
      rd_word = ID0; read_only = 1'b1;
    end else if (mmio_off == 32'h04) begin
      rd_word = ID1; read_only = 1'b1;
    end else if (mmio_off == 32'h08) begin
      rd_word = ID2; read_only = 1'b1;
    end else if (mmio_off == 32'h10) begin
      rd_word = sw_ext; read_only = 1'b1;
    end else if (led_hit) begin
      rd_word = '0;
      rd_word[LED_W-1:0] = led_q;
    end else if (ram_hit) begin
      rd_word = ram[ram_idx];
    end else begin
      mapped = 1'b0;
    end
  end

  assign err = !aligned || !mapped || (is_write && read_only);

  // ---------------- response and LED state ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      led_q     <= '0;
    end else if (accept) begin
      rsp_err   <= err;
      rsp_rdata <= (err || is_write) ? 32'h0 : rd_word;
      if (!err && is_write && led_hit) led_q <= led_wide[LED_W-1:0];
    end
  end

  // RAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (accept && !err && is_write && ram_hit)
      for (int i = 0; i < 4; i++)
        if (req_we[i]) ram[ram_idx][8*i +: 8] <= req_wdata[8*i +: 8];
  end

  assign led_out = led_q;

  // Bits intentionally left unused (high address offset bits, dropped LED bytes).
  logic unused_ok;
  assign unused_ok = &{1'b0, ram_off, led_wide};

endmodule

// File: doc/dmem_bus.md
DMEM_BUS -- requirements
Module: dmem_bus

Interface
- REQ-001 The block SHALL have parameter RAM_WORDS, default 1024, meaning number of 32-bit RAM words (power of two, 16..65536).
- REQ-002 The block SHALL have parameter RAM_BASE, default 32'h80000000, meaning byte base address of RAM.
- REQ-003 The block SHALL have parameter MMIO_BASE, default 32'h00100000, meaning byte base address of the ID/switch/LED window.
- REQ-004 The block SHALL have parameters ID0/ID1/ID2, defaults 32'h13874751/32'h18700095/32'h18313324, meaning read-only ID words.
- REQ-005 The block SHALL have parameters SW_W and LED_W, default 16 each, meaning switch and LED widths (1..32).
- REQ-006 The block SHALL have port clk, input, 1, meaning the single clock; all state is updated on its rising edge.
- REQ-007 The block SHALL have port rst, input, 1, meaning reset: asynchronous, active-high.
- REQ-008 The block SHALL have ports req_valid in 1, req_ready out 1, req_addr in 32, req_wdata in 32, req_we in 4, meaning the request channel; req_we holds per-byte write enables, and req_we==0 denotes a read.
- REQ-009 The block SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out 32, rsp_err out 1, meaning the response channel.
- REQ-010 The block SHALL have ports sw_in in SW_W and led_out out LED_W.

Function
- REQ-011 The block SHALL implement an FSM with states IDLE and RESP; req_ready SHALL be 1 only in IDLE.
- REQ-012 In IDLE with req_valid=1, the block SHALL accept the request on that edge and move to RESP with rsp_valid=1 from the next cycle; one request is outstanding at most.
- REQ-013 In RESP, the block SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE on that edge; there SHALL be no same-cycle re-accept.
- REQ-014 The address map SHALL be: MMIO_BASE+0/4/8 = ID0/ID1/ID2 (read-only); +0x10 = switches (read-only, zero-extended); +0x14 = LED register (read/write, zero-extended on read); [RAM_BASE, RAM_BASE+4*RAM_WORDS) = RAM.
- REQ-015 RAM and LED writes SHALL commit at the accept edge, per byte where req_we[i]=1; LED bits at or above LED_W SHALL be dropped.
- REQ-016 Reads SHALL capture the full word at the accept edge, ignoring byte enables; write responses SHALL return rsp_rdata=0.
- REQ-017 Read-after-write to the same address in consecutive transactions SHALL return the new data.
- REQ-018 On a misaligned address (req_addr[1:0]!=0), an unmapped address, or a write to a read-only location, the block SHALL return rsp_err=1 and rsp_rdata=0 with no state change; otherwise rsp_err=0.
- REQ-019 A write with req_we=4'b0000 is a read; a write with partial enables to a read-only location SHALL still error.
- REQ-020 led_out SHALL equal the LED register continuously.

Reset
- REQ-021 While rst=1, the block SHALL force the FSM to IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, LED register=0 and led_out=0.
- REQ-022 RAM contents SHALL NOT be cleared by reset.
- REQ-023 Reset mid-transaction SHALL drop any pending response, and the request SHALL NOT be replayed.
- REQ-024 req_ready SHALL rise on the first clk edge after rst deasserts.

Configuration
- REQ-025 When macro DMEM_SW_SYNC_EN is defined, sw_in SHALL pass through a 2-flop synchronizer (reset to 0) before being read, so a change is visible on the third edge.
- REQ-026 When DMEM_SW_SYNC_EN is undefined, sw_in SHALL be sampled directly at the accept edge.

Verification
- REQ-027 Reset, then reads of 0x00100000/04/08 -> 0x13874751, 0x18700095, 0x18313324, err=0.
- REQ-028 Write 0x00100014 data 0xFEDCBA98 we=1111 -> led_out=0xBA98; read back -> 0x0000BA98; read 0x00100010 with sw_in=0 -> 0x0.
- REQ-029 Write 0x80000010 data 0x11223344 we=1111, then 0xAABBCCDD we=0101, then read -> 0x11BB33DD.
- REQ-030 Read with rsp_ready=0 for 3 cycles -> rsp_valid held, rdata stable, req_ready=0; handshake completes on the 4th cycle.
- REQ-031 Read 0x80001000 (RAM_WORDS=1024) -> err=1, rdata=0; write 0x00100010 -> err=1 and the switch value is unchanged; read 0x80000002 -> err=1.
- REQ-032 Assert rst while in RESP -> rsp_valid=0 immediately; the LED register is 0; RAM data written earlier still reads back.
